// File: rtl/poly_wavetable_mixer.sv
// poly_wavetable_mixer: NUM_VOICES phase accumulators sharing one wavetable
// read port. Each sample tick walks the voices through the ROM, sums the
// returned samples (ungated voices contribute the DC midpoint) and presents
// the total on mix_out with a one-cycle mix_valid_out strobe.
module poly_wavetable_mixer #(
  parameter int NUM_VOICES   = 4,
  parameter int PHASE_WIDTH  = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int SAMPLE_WIDTH = 8,
  parameter int ROM_LATENCY  = 2,
  parameter int OUT_WIDTH    = SAMPLE_WIDTH + $clog2(NUM_VOICES)
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic                              sample_tick_in,
  input  logic [NUM_VOICES-1:0]             gate_in,
  input  logic [NUM_VOICES*PHASE_WIDTH-1:0] phase_inc_in,
  output logic [ADDR_WIDTH-1:0]             rom_addr_out,
  input  logic [SAMPLE_WIDTH-1:0]           rom_data_in,
  output logic [OUT_WIDTH-1:0]              mix_out,
  output logic                              mix_valid_out,
  output logic                              busy_out,
  output logic                              overrun_out
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
  localparam logic [SAMPLE_WIDTH-1:0] MID_SAMPLE = SAMPLE_WIDTH'(1) << (SAMPLE_WIDTH - 1);
  localparam logic [OUT_WIDTH-1:0] MIX_RESET = OUT_WIDTH'(NUM_VOICES) << (SAMPLE_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  state_t                  r_state;
  state_t                  w_nextState;

  logic [PHASE_WIDTH-1:0]  r_phase   [NUM_VOICES];
  logic [PHASE_WIDTH-1:0]  r_incSnap [NUM_VOICES];
  logic [NUM_VOICES-1:0]   r_gateSnap;
  logic [IDX_W-1:0]        r_idx;
  logic [IDX_W-1:0]        w_nextIdx;
  logic [OUT_WIDTH-1:0]    r_acc;
  logic [OUT_WIDTH-1:0]    r_mix;
  logic [ADDR_WIDTH-1:0]   r_romAddr;
  logic                    r_overrun;

  // Return-path delay line: marks which cycles carry ROM data, whether that
  // voice was gated, and whether it is the final voice of the frame.
  logic [ROM_LATENCY-1:0]  r_pipeVld;
  logic [ROM_LATENCY-1:0]  r_pipeGate;
  logic [ROM_LATENCY-1:0]  r_pipeLast;

  logic                    w_issue;
  logic [SAMPLE_WIDTH-1:0] w_contrib;

  assign w_issue   = (r_state == ISSUE);
  assign w_nextIdx = r_idx + 1'b1;
  assign w_contrib = r_pipeGate[ROM_LATENCY-1] ? rom_data_in : MID_SAMPLE;

  // State register; reset always lands in IDLE, dropping any coincident tick.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: one ISSUE cycle per voice, then wait for the last
  // voice's data to be summed before publishing in DONE.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (sample_tick_in) w_nextState = ISSUE;
      ISSUE:   if (r_idx == LAST_IDX) w_nextState = DRAIN;
      DRAIN:   if (r_pipeLast[ROM_LATENCY-1]) w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Delay line tracking ROM reads in flight; cleared on reset so an aborted
  // frame's returning data is never summed.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_pipeVld  <= '0;
      r_pipeGate <= '0;
      r_pipeLast <= '0;
    end else begin
      r_pipeVld[0]  <= w_issue;
      r_pipeGate[0] <= r_gateSnap[r_idx];
      r_pipeLast[0] <= w_issue && (r_idx == LAST_IDX);
      for (int i = 1; i < ROM_LATENCY; i++) begin
        r_pipeVld[i]  <= r_pipeVld[i-1];
        r_pipeGate[i] <= r_pipeGate[i-1];
        r_pipeLast[i] <= r_pipeLast[i-1];
      end
    end
  end

  // Frame datapath: snapshot inputs on the tick, advance or zero each phase
  // as it is issued, pre-load the next voice's address so the registered
  // address lines up with its ISSUE cycle, and accumulate returning data.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        r_phase[v]   <= '0;
        r_incSnap[v] <= '0;
      end
      r_gateSnap <= '0;
      r_idx      <= '0;
      r_acc      <= '0;
      r_mix      <= MIX_RESET;
      r_romAddr  <= '0;
      r_overrun  <= 1'b0;
    end else begin
      if (sample_tick_in && (r_state != IDLE)) begin
        r_overrun <= 1'b1;
      end
      if (r_pipeVld[ROM_LATENCY-1]) begin
        r_acc <= r_acc + OUT_WIDTH'(w_contrib);
      end
      case (r_state)
        IDLE: begin
          if (sample_tick_in) begin
            r_gateSnap <= gate_in;
            for (int v = 0; v < NUM_VOICES; v++) begin
              r_incSnap[v] <= phase_inc_in[v*PHASE_WIDTH +: PHASE_WIDTH];
            end
            r_acc     <= '0;
            r_idx     <= '0;
            r_romAddr <= r_phase[0][PHASE_WIDTH-1 -: ADDR_WIDTH];
          end
        end
        ISSUE: begin
          if (r_gateSnap[r_idx]) begin
            r_phase[r_idx] <= r_phase[r_idx] + r_incSnap[r_idx];
          end else begin
            r_phase[r_idx] <= '0;
          end
          if (r_idx != LAST_IDX) begin
            r_idx     <= w_nextIdx;
            r_romAddr <= r_phase[w_nextIdx][PHASE_WIDTH-1 -: ADDR_WIDTH];
          end
        end
        DONE: begin
          r_mix <= r_acc;
        end
        default: begin
        end
      endcase
    end
  end

  assign rom_addr_out  = r_romAddr;
  assign mix_valid_out = (r_state == DONE);
  assign mix_out       = (r_state == DONE) ? r_acc : r_mix;
  assign busy_out      = (r_state != IDLE);
  assign overrun_out   = r_overrun;

endmodule

// File: tb/tb_poly_wavetable_mixer.sv
// Scoreboard bench for poly_wavetable_mixer: directed frames push the
// hand-computed mix value and pulse cycle; a monitor pops on every pulse.
module tb_poly_wavetable_mixer;

  localparam int NV = 4;
  localparam int PW = 32;
  localparam int AW = 8;
  localparam int SW = 8;
  localparam int RL = 2;
  localparam int OW = 10;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          sample_tick_in;
  logic [NV-1:0] gate_in;
  logic [NV*PW-1:0] phase_inc_in;
  logic [AW-1:0] rom_addr_out;
  logic [SW-1:0] rom_data_in;
  logic [OW-1:0] mix_out;
  logic          mix_valid_out;
  logic          busy_out;
  logic          overrun_out;

  int compared   = 0;
  int mismatched = 0;
  int cycleCount = 0;
  int expMixQ[$];
  int expCycQ[$];
  bit romConst   = 1'b0;
  logic [SW-1:0] romD1 = '0;
  logic [SW-1:0] romD2 = '0;

  poly_wavetable_mixer #(
    .NUM_VOICES(NV), .PHASE_WIDTH(PW), .ADDR_WIDTH(AW),
    .SAMPLE_WIDTH(SW), .ROM_LATENCY(RL)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .sample_tick_in(sample_tick_in),
    .gate_in(gate_in), .phase_inc_in(phase_inc_in),
    .rom_addr_out(rom_addr_out), .rom_data_in(rom_data_in),
    .mix_out(mix_out), .mix_valid_out(mix_valid_out),
    .busy_out(busy_out), .overrun_out(overrun_out)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cycleCount <= cycleCount + 1;

  // Two-stage registered ROM: identity table or constant full scale.
  always @(posedge clk_in) begin
    romD1 <= romConst ? 8'hFF : rom_addr_out;
    romD2 <= romD1;
  end
  assign rom_data_in = romD2;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycleCount);
    end
  endtask

  // Monitor: every pulse must match the oldest outstanding expectation.
  initial begin
    int m;
    int c;
    forever begin
      @(negedge clk_in);
      if (mix_valid_out === 1'b1) begin
        if (expMixQ.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_pulse: got mix_valid_out=1 mix_out=%0d, expected no pulse (cycle %0d)", mix_out, cycleCount);
        end else begin
          m = expMixQ.pop_front();
          c = expCycQ.pop_front();
          checkOutput("mix_out", 32'(mix_out), 32'(m));
          checkOutput("pulse_cycle", 32'(cycleCount), 32'(c));
        end
      end
    end
  end

  task automatic waitIdle();
    int n = 0;
    while (busy_out !== 1'b0 && n < 30) begin
      @(negedge clk_in);
      n++;
    end
    if (n >= 30) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL idle_timeout: got busy_out still high after %0d cycles, expected idle", n);
    end
  endtask

  task automatic doReset();
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  task automatic setVoices(input logic [NV-1:0] gates, input logic [PW-1:0] inc);
    gate_in = gates;
    for (int v = 0; v < NV; v++) phase_inc_in[v*PW +: PW] = inc;
  endtask

  // One full frame: tick, record expectation, check voice-0 address.
  task automatic applyStimulus(input logic [AW-1:0] expAddr, input int expMix);
    @(negedge clk_in);
    sample_tick_in = 1'b1;
    expMixQ.push_back(expMix);
    expCycQ.push_back(cycleCount + 7);
    @(negedge clk_in);
    sample_tick_in = 1'b0;
    checkOutput("voice0_addr", 32'(rom_addr_out), 32'(expAddr));
    checkOutput("busy_during_frame", 32'(busy_out), 32'd1);
    waitIdle();
  endtask

  initial begin
    logic [AW-1:0] wrapAddr [5];
    wrapAddr = '{8'd0, 8'd64, 8'd128, 8'd192, 8'd0};
    rst_in = 1'b1;
    sample_tick_in = 1'b0;
    gate_in = '0;
    phase_inc_in = '0;
    repeat (3) @(negedge clk_in);
    checkOutput("reset_mix", 32'(mix_out), 32'd512);
    checkOutput("reset_valid", 32'(mix_valid_out), 32'd0);
    checkOutput("reset_busy", 32'(busy_out), 32'd0);
    checkOutput("reset_overrun", 32'(overrun_out), 32'd0);
    checkOutput("reset_addr", 32'(rom_addr_out), 32'd0);
    rst_in = 1'b0;

    $display("[TB] single voice ramp");
    setVoices(4'b0001, 32'h0100_0000);
    for (int k = 0; k < 4; k++) applyStimulus(AW'(k), 384 + k);

    $display("[TB] phase wrap");
    doReset();
    setVoices(4'b0001, 32'h4000_0000);
    for (int k = 0; k < 5; k++) applyStimulus(wrapAddr[k], 384 + int'(wrapAddr[k]));

    $display("[TB] full scale");
    doReset();
    romConst = 1'b1;
    setVoices(4'b1111, 32'h0100_0000);
    applyStimulus(8'd0, 1020);
    applyStimulus(8'd1, 1020);
    romConst = 1'b0;

    $display("[TB] gate release and retrigger");
    doReset();
    setVoices(4'b0001, 32'h0100_0000);
    applyStimulus(8'd0, 384);
    applyStimulus(8'd1, 385);
    gate_in = 4'b0000;
    applyStimulus(8'd2, 512);
    gate_in = 4'b0001;
    applyStimulus(8'd0, 384);

    $display("[TB] overrun");
    @(negedge clk_in);
    sample_tick_in = 1'b1;
    expMixQ.push_back(385);
    expCycQ.push_back(cycleCount + 7);
    @(negedge clk_in);
    sample_tick_in = 1'b0;
    checkOutput("overrun_addr", 32'(rom_addr_out), 32'd1);
    @(negedge clk_in);
    sample_tick_in = 1'b1;
    @(negedge clk_in);
    sample_tick_in = 1'b0;
    checkOutput("overrun_set", 32'(overrun_out), 32'd1);
    waitIdle();
    checkOutput("overrun_sticky", 32'(overrun_out), 32'd1);
    applyStimulus(8'd2, 386);
    checkOutput("overrun_still", 32'(overrun_out), 32'd1);

    $display("[TB] reset after ticks");
    doReset();
    checkOutput("rst_mix", 32'(mix_out), 32'd512);
    checkOutput("rst_valid", 32'(mix_valid_out), 32'd0);
    checkOutput("rst_busy", 32'(busy_out), 32'd0);
    checkOutput("rst_overrun", 32'(overrun_out), 32'd0);

    $display("[TB] reset mid-frame");
    @(negedge clk_in);
    sample_tick_in = 1'b1;
    @(negedge clk_in);
    sample_tick_in = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    checkOutput("abort_busy", 32'(busy_out), 32'd0);
    checkOutput("abort_mix", 32'(mix_out), 32'd512);
    repeat (8) @(negedge clk_in);
    applyStimulus(8'd0, 384);

    $display("[TB] reset with coincident tick");
    @(negedge clk_in);
    rst_in = 1'b1;
    sample_tick_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    sample_tick_in = 1'b0;
    checkOutput("rst_tick_busy", 32'(busy_out), 32'd0);
    repeat (8) @(negedge clk_in);
    applyStimulus(8'd0, 384);

    repeat (3) @(negedge clk_in);
    checkOutput("pending_expectations", 32'(expMixQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
